// File: rtl/pps_tune_pkg.sv
// rtl/pps_tune_pkg.sv - shared state encodings, defaults and tune integrator step
package pps_tune_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2,
    ST_HOLD = 2'd3
  } pps_state_t;

  localparam int unsigned DEF_NOMINAL = 30720000;
  localparam int unsigned DEF_TOL     = 3072;

  // Step is clamped to +/-4095 first, then the 14-bit sum is clamped to 0..4095.
  function automatic logic [11:0] tune_step(input logic [11:0] tune,
                                            input logic signed [32:0] err,
                                            input int unsigned shift,
                                            input bit pol);
    logic signed [32:0] s;
    logic signed [12:0] st;
    logic signed [13:0] sum;
    s = err >>> shift;
    if (s > 33'sd4095)       st = 13'sd4095;
    else if (s < -33'sd4095) st = -13'sd4095;
    else                     st = s[12:0];
    if (pol) sum = $signed({2'b00, tune}) + $signed({st[12], st});
    else     sum = $signed({2'b00, tune}) - $signed({st[12], st});
    if (sum < 14'sd0)         return 12'd0;
    else if (sum > 14'sd4095) return 12'd4095;
    else                      return sum[11:0];
  endfunction

endpackage

// File: rtl/pps_period_meas.sv
// rtl/pps_period_meas.sv - PPS period from successive captures plus missing-PPS watchdog
module pps_period_meas #(
  parameter int unsigned WD_LIMIT = 30723073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        cap_stb,
  input  logic [31:0] cap_val,
  output logic [31:0] period,
  output logic        period_stb,
  output logic        miss
);

  logic [31:0] prev_cap;
  logic        have_prev;
  logic [31:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cap   <= '0;
      have_prev  <= 1'b0;
      period     <= '0;
      period_stb <= 1'b0;
      miss       <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      period_stb <= 1'b0;
      miss       <= 1'b0;
      if (clr) begin
        have_prev <= 1'b0;
        wd_cnt    <= '0;
      end else if (cap_stb) begin
        // Modular subtraction makes free-running counter wrap transparent.
        prev_cap  <= cap_val;
        have_prev <= 1'b1;
        wd_cnt    <= '0;
        if (have_prev) begin
          period     <= cap_val - prev_cap;
          period_stb <= 1'b1;
        end
      end else if (wd_cnt == WD_LIMIT - 1) begin
        wd_cnt <= '0;
        miss   <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pps_tune_loop.sv
// rtl/pps_tune_loop.sv - GPS PPS disciplining loop: error stage, lock FSM, tune integrator
module pps_tune_loop
  import pps_tune_pkg::*;
#(
  parameter int unsigned NOMINAL    = DEF_NOMINAL,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned ACQ_N      = 3,
  parameter int unsigned HOLD_MAX   = 60,
  parameter int unsigned GAIN_SHIFT = 2,
  parameter bit          POL        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] tune_init,
  input  logic        cap_stb,
  input  logic [31:0] cap_val,
  output logic [11:0] tune_val,
  output logic        tune_oe,
  output logic [1:0]  state,
  output logic [15:0] err_val,
  output logic        err_stb
);

  localparam logic signed [32:0] NOM_S  = 33'(NOMINAL);
  localparam logic signed [32:0] TOL_S  = 33'(TOL);
  localparam logic signed [32:0] SAT_HI = 33'sd32767;

  pps_state_t         state_q, state_d;
  logic [7:0]         acq_q, acq_d, hold_q, hold_d, hold_inc;
  logic [11:0]        tune_q, tune_d;
  logic [31:0]        period;
  logic               period_stb, miss, flush;
  logic signed [32:0] err_c, err_q;
  logic [15:0]        err_sat;
  logic               valid_q, ev_valid, ev_bad;

  // Leaving IDLE must always start from a fresh capture, so IDLE also flushes.
  assign flush = !en || (state_q == ST_IDLE);

  pps_period_meas #(.WD_LIMIT(NOMINAL + TOL + 1)) u_meas (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .cap_stb    (cap_stb),
    .cap_val    (cap_val),
    .period     (period),
    .period_stb (period_stb),
    .miss       (miss)
  );

  assign err_c = $signed({1'b0, period}) - NOM_S;

  always_comb begin
    if (err_c > SAT_HI)       err_sat = 16'h7fff;
    else if (err_c < -SAT_HI) err_sat = 16'h8001;
    else                      err_sat = err_c[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      valid_q <= 1'b0;
      err_val <= '0;
      err_stb <= 1'b0;
    end else begin
      err_stb <= 1'b0;
      if (period_stb && !flush) begin
        err_q   <= err_c;
        valid_q <= (err_c <= TOL_S) && (err_c >= -TOL_S);
        err_val <= err_sat;
        err_stb <= 1'b1;
      end
    end
  end

  // A period result takes precedence over a watchdog miss landing together.
  assign ev_valid = err_stb && valid_q;
  assign ev_bad   = (err_stb && !valid_q) || (miss && !err_stb);
  assign hold_inc = hold_q + 8'd1;

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    hold_d  = hold_q;
    tune_d  = tune_q;
    if (!en) begin
      state_d = ST_IDLE;
      acq_d   = '0;
      hold_d  = '0;
      tune_d  = tune_init;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          acq_d   = '0;
          tune_d  = tune_init;
        end
        ST_ACQ: begin
          if (ev_valid) begin
            if (acq_q == 8'(ACQ_N - 1)) begin
              state_d = ST_LOCK;
              acq_d   = '0;
            end else begin
              acq_d = acq_q + 8'd1;
            end
          end else if (ev_bad) begin
            acq_d = '0;
          end
        end
        ST_LOCK: begin
          if (ev_valid) begin
            tune_d = tune_step(tune_q, err_q, GAIN_SHIFT, POL);
          end else if (ev_bad) begin
            state_d = ST_HOLD;
            hold_d  = 8'd1;
          end
        end
        ST_HOLD: begin
          if (ev_valid) begin
            state_d = ST_LOCK;
            hold_d  = '0;
            tune_d  = tune_step(tune_q, err_q, GAIN_SHIFT, POL);
          end else if (ev_bad) begin
            if (hold_inc == 8'(HOLD_MAX)) begin
              state_d = ST_IDLE;
              hold_d  = '0;
              tune_d  = tune_init;
            end else begin
              hold_d = hold_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acq_q   <= '0;
      hold_q  <= '0;
      tune_q  <= '0;
      tune_oe <= 1'b0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
      hold_q  <= hold_d;
      tune_q  <= tune_d;
      tune_oe <= en;
    end
  end

  assign tune_val = tune_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pps_tune_loop.sv
// tb/tb_pps_tune_loop.sv - directed checks of acquisition, lock, hold, saturation and reset
module tb_pps_tune_loop;

  localparam int unsigned NOM   = 3000;
  localparam int unsigned TOLV  = 1200;
  localparam int unsigned LIMIT = NOM + TOLV + 1;

  logic        clk = 1'b0;
  logic        rst, en, cap_stb;
  logic [11:0] tune_init;
  logic [31:0] cap_val;
  logic [11:0] tune_val;
  logic        tune_oe, err_stb;
  logic [1:0]  state;
  logic [15:0] err_val;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] cur;
  logic        obs_stb1, obs_stb2;
  logic [15:0] obs_err;
  logic [11:0] obs_tune2, obs_tune;
  logic [1:0]  obs_state;
  int          k;

  pps_tune_loop #(
    .NOMINAL(NOM), .TOL(TOLV), .ACQ_N(3), .HOLD_MAX(3), .GAIN_SHIFT(2), .POL(1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tune_init (tune_init),
    .cap_stb   (cap_stb),
    .cap_val   (cap_val),
    .tune_val  (tune_val),
    .tune_oe   (tune_oe),
    .state     (state),
    .err_val   (err_val),
    .err_stb   (err_stb)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Observes err_stb at N+1/N+2 and state/tune at N+3 relative to the strobe cycle N.
  task automatic send_cap(input logic [31:0] v);
    cap_val = v;
    cap_stb = 1'b1;
    cyc();
    cap_stb  = 1'b0;
    obs_stb1 = err_stb;
    cyc();
    obs_stb2  = err_stb;
    obs_err   = err_val;
    obs_tune2 = tune_val;
    cyc();
    obs_state = state;
    obs_tune  = tune_val;
    repeat (2) cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cap_stb = 1'b0; cap_val = '0; tune_init = 12'd2048;
    repeat (2) cyc();
    check("rst_tune", tune_val, 0);
    check("rst_oe", tune_oe, 0);
    check("rst_state", state, 0);
    check("rst_err", err_val, 0);
    check("rst_stb", err_stb, 0);
    rst = 1'b0;
    repeat (2) cyc();

    // Acquisition with exact periods
    en = 1'b1;
    cyc();
    check("acq_state", state, 1);
    check("acq_oe", tune_oe, 1);
    check("acq_tune", tune_val, 2048);
    cur = 32'h1000_0000;
    send_cap(cur);
    check("first_cap_no_stb", obs_stb2, 0);
    cur += NOM; send_cap(cur);
    cur += NOM; send_cap(cur);
    check("acq_after_2valid", obs_state, 1);
    check("acq_err0", obs_err, 0);
    cur += NOM; send_cap(cur);
    check("lock_state", obs_state, 2);
    check("lock_tune", obs_tune, 2048);

    // Positive error, latency of err_stb and tune update
    cur += NOM + 400; send_cap(cur);
    check("err_stb_n1", obs_stb1, 0);
    check("err_stb_n2", obs_stb2, 1);
    check("err_400", obs_err, 400);
    check("tune_n2", obs_tune2, 2048);
    check("tune_n3", obs_tune, 1948);

    // Drive tune down to 10 then past zero, then up to 4090 then past 4095
    for (int i = 0; i < 6; i++) begin cur += NOM + 1200; send_cap(cur); end
    check("tune_148", obs_tune, 148);
    cur += NOM + 552; send_cap(cur);
    check("tune_10", obs_tune, 10);
    cur += NOM + 1000; send_cap(cur);
    check("tune_sat0", obs_tune, 0);
    for (int i = 0; i < 13; i++) begin cur += NOM - 1200; send_cap(cur); end
    cur += NOM - 760; send_cap(cur);
    check("tune_4090", obs_tune, 4090);
    cur += NOM - 1000; send_cap(cur);
    check("err_neg1000", obs_err, 16'hfc18);
    check("tune_sat4095", obs_tune, 4095);
    check("still_lock", obs_state, 2);

    // Missing PPS -> HOLD after watchdog limit
    cur += NOM;
    cap_val = cur; cap_stb = 1'b1;
    cyc();
    cap_stb = 1'b0;
    k = 1;
    while (state != 2'd3 && k < 2 * LIMIT) begin cyc(); k++; end
    check("miss_latency", k, LIMIT + 2);
    check("hold_state", state, 3);
    check("hold_tune", tune_val, 4095);
    cur += 2 * NOM + 50000; send_cap(cur);
    check("err_sat_pos", obs_err, 16'h7fff);
    check("hold_after_invalid", obs_state, 3);
    check("hold_tune_frozen", obs_tune, 4095);
    cur += NOM; send_cap(cur);
    check("relock", obs_state, 2);

    // Counter wrap: invalid jump to HOLD, then a wrapped valid period relocks
    cur = 32'hffff_ff00; send_cap(cur);
    check("wrap_pre_hold", obs_state, 3);
    cur = 32'h0000_0ab8; send_cap(cur);
    check("wrap_err0", obs_err, 0);
    check("wrap_stb", obs_stb2, 1);
    check("wrap_lock", obs_state, 2);

    // Repeated misses exhaust HOLD_MAX=3 -> IDLE with tune_init
    k = 0;
    while (state != 2'd0 && k < 4 * LIMIT) begin cyc(); k++; end
    check("holdmax_idle", state, 0);
    check("holdmax_tune", tune_val, 2048);
    cyc();
    check("idle_to_acq", state, 1);

    // Re-lock, then drop en together with a capture
    cur = 32'h2000_0000; send_cap(cur);
    for (int i = 0; i < 3; i++) begin cur += NOM; send_cap(cur); end
    check("relock2", obs_state, 2);
    tune_init = 12'd1000;
    cur += NOM + 400;
    cap_val = cur; cap_stb = 1'b1; en = 1'b0;
    cyc();
    cap_stb = 1'b0;
    check("en_off_idle", state, 0);
    check("en_off_oe", tune_oe, 0);
    check("en_off_tune", tune_val, 1000);
    check("en_off_stb_n1", err_stb, 0);
    cyc();
    check("en_off_stb_n2", err_stb, 0);

    // Lock again, go to HOLD, then asynchronous reset
    en = 1'b1;
    cyc();
    cur = 32'h3000_0000; send_cap(cur);
    for (int i = 0; i < 3; i++) begin cur += NOM; send_cap(cur); end
    check("lock3_tune", obs_tune, 1000);
    cur += NOM + 2000; send_cap(cur);
    check("hold3_state", obs_state, 3);
    check("hold3_err", obs_err, 2000);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tune", tune_val, 0);
    check("arst_oe", tune_oe, 0);
    check("arst_state", state, 0);
    check("arst_err", err_val, 0);
    check("arst_stb", err_stb, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
